// File: rtl/avalon_mm_arbiter.sv
// avalon_mm_arbiter: N-host to 1-agent Avalon-MM arbiter with one outstanding transfer.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module avalon_mm_arbiter #(
    parameter  int NUM_HOSTS = 2,
    parameter  int ADDR_W    = 32,
    parameter  int DATA_W    = 32,
    localparam int BE_W      = DATA_W / 8,
    localparam int GW        = $clog2(NUM_HOSTS)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_HOSTS*ADDR_W-1:0] h_address,
    input  logic [NUM_HOSTS*BE_W-1:0]   h_byteenable,
    input  logic [NUM_HOSTS-1:0]        h_read,
    input  logic [NUM_HOSTS-1:0]        h_write,
    input  logic [NUM_HOSTS*DATA_W-1:0] h_writedata,
    output logic [NUM_HOSTS-1:0]        h_waitrequest,
    output logic [DATA_W-1:0]           h_readdata,
    output logic [NUM_HOSTS-1:0]        h_readdatavalid,
    output logic [ADDR_W-1:0]           a_address,
    output logic [BE_W-1:0]             a_byteenable,
    output logic                        a_read,
    output logic                        a_write,
    output logic [DATA_W-1:0]           a_writedata,
    input  logic                        a_waitrequest,
    input  logic [DATA_W-1:0]           a_readdata,
    input  logic                        a_readdatavalid,
    output logic [GW-1:0]               grant_idx,
    output logic                        busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_e;

    state_e                  state_q, state_d;
    logic [GW-1:0]           grant_q, grant_d, win;
    logic [NUM_HOSTS-1:0]    req;
    logic [ADDR_W-1:0]       addr_a [NUM_HOSTS];
    logic [BE_W-1:0]         be_a   [NUM_HOSTS];
    logic [DATA_W-1:0]       wd_a   [NUM_HOSTS];
    logic                    g_read, g_write, issue, accept, done, rdv;

    assign req     = h_read | h_write;
    assign g_read  = h_read[grant_q];
    assign g_write = h_write[grant_q];
    assign issue   = state_q == ISSUE;
    assign accept  = issue && !a_waitrequest;
    // A write, or a read answered in its accept cycle, finishes without visiting WAIT_DATA
    assign done    = (accept && (g_write || !g_read || a_readdatavalid)) || (state_q == WAIT_DATA && a_readdatavalid);
    assign rdv     = (accept && g_read && !g_write && a_readdatavalid) || (state_q == WAIT_DATA && a_readdatavalid);

    for (genvar g = 0; g < NUM_HOSTS; g++) begin : g_slice
        assign addr_a[g] = h_address[g*ADDR_W +: ADDR_W];
        assign be_a[g]   = h_byteenable[g*BE_W +: BE_W];
        assign wd_a[g]   = h_writedata[g*DATA_W +: DATA_W];
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic [GW-1:0] ptr_q, ptr_d;

    // Next search start is the host after the one that last completed a transfer
    assign ptr_d = done ? (grant_q == GW'(NUM_HOSTS - 1) ? '0 : grant_q + 1'b1) : ptr_q;

    // Round-robin pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end

    // Search from ptr_q upwards with wrap; the closest requester to the pointer wins
    always_comb begin
        win = ptr_q;
        for (int k = NUM_HOSTS - 1; k >= 0; k--)
            if (req[(int'(ptr_q) + k) % NUM_HOSTS]) win = GW'((int'(ptr_q) + k) % NUM_HOSTS);
    end
`else
    // Fixed priority: the lowest requesting index wins
    always_comb begin
        win = '0;
        for (int k = NUM_HOSTS - 1; k >= 0; k--)
            if (req[k]) win = GW'(k);
    end
`endif

    // State and grant registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // Next-state logic; the grant is captured only when leaving IDLE
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: if (|req) begin
                state_d = ISSUE;
                grant_d = win;
            end
            ISSUE:     if (accept) state_d = done ? IDLE : WAIT_DATA;
            WAIT_DATA: if (a_readdatavalid) state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Outputs: agent mirrors the granted host only while issuing; everyone else sees its own request as stall
    always_comb begin
        a_read          = issue & g_read & ~g_write;
        a_write         = issue & g_write;
        a_address       = issue ? addr_a[grant_q] : '0;
        a_byteenable    = issue ? be_a[grant_q] : '0;
        a_writedata     = issue ? wd_a[grant_q] : '0;
        h_waitrequest   = req;
        if (issue) h_waitrequest[grant_q] = a_waitrequest;
        h_readdatavalid = '0;
        if (rdv) h_readdatavalid[grant_q] = 1'b1;
        h_readdata      = rdv ? a_readdata : '0;
        busy            = state_q != IDLE;
        grant_idx       = grant_q;
    end

    // The granted host must hold its request until the agent accepts it
    hold_req_a: assert property (@(posedge clk) disable iff (!rst_n) issue |-> req[grant_q]);

endmodule

// File: tb/tb_avalon_mm_arbiter.sv
// tb_avalon_mm_arbiter: directed vector table plus hand sequences for stall and reset corners.
module tb_avalon_mm_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   h_read, h_write, h_waitrequest, h_readdatavalid;
    logic [127:0] h_address, h_writedata;
    logic [15:0]  h_byteenable;
    logic [31:0]  h_readdata, a_address, a_writedata, a_readdata;
    logic [3:0]   a_byteenable;
    logic         a_read, a_write, a_waitrequest, a_readdatavalid, busy;
    logic [1:0]   grant_idx;
    int           tests = 0;
    int           fails = 0;

    logic [31:0] addr_t [4] = '{32'h40, 32'h100, 32'h200, 32'h300};
    logic [31:0] wd_t   [4] = '{32'h0A0A0A0A, 32'hDEADBEEF, 32'h22222222, 32'h33333333};
    logic [3:0]  be_t   [4] = '{4'hF, 4'hF, 4'h3, 4'hC};

    assign h_address    = {addr_t[3], addr_t[2], addr_t[1], addr_t[0]};
    assign h_writedata  = {wd_t[3], wd_t[2], wd_t[1], wd_t[0]};
    assign h_byteenable = {be_t[3], be_t[2], be_t[1], be_t[0]};

    always #5 clk = ~clk;

    avalon_mm_arbiter #(.NUM_HOSTS(4), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .h_address(h_address), .h_byteenable(h_byteenable), .h_read(h_read), .h_write(h_write),
        .h_writedata(h_writedata), .h_waitrequest(h_waitrequest), .h_readdata(h_readdata),
        .h_readdatavalid(h_readdatavalid), .a_address(a_address), .a_byteenable(a_byteenable),
        .a_read(a_read), .a_write(a_write), .a_writedata(a_writedata), .a_waitrequest(a_waitrequest),
        .a_readdata(a_readdata), .a_readdatavalid(a_readdatavalid), .grant_idx(grant_idx), .busy(busy)
    );

    typedef struct {
        logic [3:0]  r, w;
        logic        aw, arv;
        logic [31:0] ard;
        logic        ar_e, awr_e;
        logic [3:0]  hw_e, hrv_e;
        logic [31:0] hrd_e;
        logic [1:0]  g_e;
        logic        busy_e, iss_e;
    } vec_t;

    vec_t v [23];

    function automatic vec_t mk(logic [3:0] r, logic [3:0] w, logic aw, logic arv, logic [31:0] ard,
                                logic ar_e, logic awr_e, logic [3:0] hw_e, logic [3:0] hrv_e,
                                logic [31:0] hrd_e, logic [1:0] g_e, logic busy_e, logic iss_e);
        vec_t x;
        x.r = r; x.w = w; x.aw = aw; x.arv = arv; x.ard = ard;
        x.ar_e = ar_e; x.awr_e = awr_e; x.hw_e = hw_e; x.hrv_e = hrv_e;
        x.hrd_e = hrd_e; x.g_e = g_e; x.busy_e = busy_e; x.iss_e = iss_e;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // inputs: r, w, aw, arv, ard | expected: a_read, a_write, h_wait, h_rdv, h_rdata, grant, busy, issuing
        v[0]  = mk(4'b0000, 4'b0000, 0, 0, 32'h0,        0, 0, 4'b0000, 4'b0000, 32'h0,        0, 0, 0);
        v[1]  = mk(4'b0000, 4'b0000, 0, 1, 32'h55,       0, 0, 4'b0000, 4'b0000, 32'h0,        0, 0, 0);
        v[2]  = mk(4'b0000, 4'b0010, 0, 0, 32'h0,        0, 0, 4'b0010, 4'b0000, 32'h0,        0, 0, 0);
        v[3]  = mk(4'b0000, 4'b0010, 0, 0, 32'h0,        0, 1, 4'b0000, 4'b0000, 32'h0,        1, 1, 1);
        v[4]  = mk(4'b0000, 4'b0000, 0, 0, 32'h0,        0, 0, 4'b0000, 4'b0000, 32'h0,        1, 0, 0);
        v[5]  = mk(4'b0001, 4'b0000, 0, 0, 32'h0,        0, 0, 4'b0001, 4'b0000, 32'h0,        1, 0, 0);
        v[6]  = mk(4'b0001, 4'b0000, 0, 0, 32'h0,        1, 0, 4'b0000, 4'b0000, 32'h0,        0, 1, 1);
        v[7]  = mk(4'b0000, 4'b0000, 0, 0, 32'h0,        0, 0, 4'b0000, 4'b0000, 32'h0,        0, 1, 0);
        v[8]  = mk(4'b0000, 4'b0000, 0, 0, 32'h0,        0, 0, 4'b0000, 4'b0000, 32'h0,        0, 1, 0);
        v[9]  = mk(4'b0000, 4'b0000, 0, 1, 32'h12345678, 0, 0, 4'b0000, 4'b0001, 32'h12345678, 0, 1, 0);
        v[10] = mk(4'b0000, 4'b0000, 0, 0, 32'h0,        0, 0, 4'b0000, 4'b0000, 32'h0,        0, 0, 0);
        v[11] = mk(4'b1111, 4'b0000, 0, 0, 32'h0,        0, 0, 4'b1111, 4'b0000, 32'h0,        0, 0, 0);
        v[12] = mk(4'b1111, 4'b0000, 0, 1, 32'hCAFE,     1, 0, 4'b1110, 4'b0001, 32'hCAFE,     0, 1, 1);
        v[13] = mk(4'b1111, 4'b0000, 0, 0, 32'h0,        0, 0, 4'b1111, 4'b0000, 32'h0,        0, 0, 0);
        v[14] = mk(4'b1111, 4'b0000, 0, 1, 32'hCAFE,     1, 0, 4'b1110, 4'b0001, 32'hCAFE,     0, 1, 1);
        v[15] = mk(4'b1110, 4'b0000, 0, 0, 32'h0,        0, 0, 4'b1110, 4'b0000, 32'h0,        0, 0, 0);
        v[16] = mk(4'b1110, 4'b0000, 1, 0, 32'h0,        1, 0, 4'b1110, 4'b0000, 32'h0,        1, 1, 1);
        v[17] = mk(4'b1110, 4'b0000, 0, 0, 32'h0,        1, 0, 4'b1100, 4'b0000, 32'h0,        1, 1, 1);
        v[18] = mk(4'b1100, 4'b0000, 0, 0, 32'h0,        0, 0, 4'b1100, 4'b0000, 32'h0,        1, 1, 0);
        v[19] = mk(4'b1100, 4'b0000, 0, 1, 32'hBEEF,     0, 0, 4'b1100, 4'b0010, 32'hBEEF,     1, 1, 0);
        v[20] = mk(4'b0100, 4'b0100, 0, 0, 32'h0,        0, 0, 4'b0100, 4'b0000, 32'h0,        1, 0, 0);
        v[21] = mk(4'b0100, 4'b0100, 0, 1, 32'h77,       0, 1, 4'b0000, 4'b0000, 32'h0,        2, 1, 1);
        v[22] = mk(4'b0000, 4'b0000, 0, 0, 32'h0,        0, 0, 4'b0000, 4'b0000, 32'h0,        2, 0, 0);

        rst_n = 1'b0;
        h_read = 4'b0001; h_write = 4'b0000;
        a_waitrequest = 1'b0; a_readdatavalid = 1'b0; a_readdata = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {a_read, a_write, h_waitrequest, h_readdatavalid, h_readdata, grant_idx, busy, a_address},
            {1'b0, 1'b0, 4'b0001, 4'b0000, 32'h0, 2'd0, 1'b0, 32'h0});
        nxt;
        h_read = 4'b0000;
        rst_n = 1'b1;

        foreach (v[i]) begin
            nxt;
            h_read = v[i].r; h_write = v[i].w;
            a_waitrequest = v[i].aw; a_readdatavalid = v[i].arv; a_readdata = v[i].ard;
            @(negedge clk);
            chk($sformatf("vec%0d", i),
                {a_read, a_write, h_waitrequest, h_readdatavalid, h_readdata, grant_idx, busy,
                 a_address, a_writedata, a_byteenable},
                {v[i].ar_e, v[i].awr_e, v[i].hw_e, v[i].hrv_e, v[i].hrd_e, v[i].g_e, v[i].busy_e,
                 v[i].iss_e ? addr_t[v[i].g_e] : 32'h0, v[i].iss_e ? wd_t[v[i].g_e] : 32'h0,
                 v[i].iss_e ? be_t[v[i].g_e] : 4'h0});
        end

        // Agent stall on a host0 write while host2 waits with a read
        nxt;
        h_write = 4'b0001; h_read = 4'b0100; a_waitrequest = 1'b1; a_readdatavalid = 1'b0;
        @(negedge clk);
        chk("stall_idle", {h_waitrequest, busy}, {4'b0101, 1'b0});
        for (int c = 0; c < 5; c++) begin
            nxt;
            @(negedge clk);
            chk($sformatf("stall_cyc%0d", c), {a_write, a_read, a_address, a_writedata, h_waitrequest, grant_idx},
                {1'b1, 1'b0, 32'h40, 32'h0A0A0A0A, 4'b0101, 2'd0});
        end
        nxt;
        a_waitrequest = 1'b0;
        @(negedge clk);
        chk("stall_accept", {a_write, h_waitrequest}, {1'b1, 4'b0100});
        nxt;
        h_write = 4'b0000;
        @(negedge clk);
        chk("stall_done", {a_write, busy, h_waitrequest}, {1'b0, 1'b0, 4'b0100});

        // Host2 read accepted, then reset while waiting for data
        nxt;
        @(negedge clk);
        chk("rd2_issue", {a_read, grant_idx, a_address, a_byteenable}, {1'b1, 2'd2, 32'h200, 4'h3});
        nxt;
        h_read = 4'b0000;
        @(negedge clk);
        chk("rd2_wait", {a_read, busy}, {1'b0, 1'b1});
        nxt;
        rst_n = 1'b0;
        h_read = 4'b0100;
        #1;
        chk("rst_mid", {busy, grant_idx, a_read, h_waitrequest}, {1'b0, 2'd0, 1'b0, 4'b0100});
        nxt;
        h_read = 4'b0000;
        rst_n = 1'b1;
        nxt;
        a_readdatavalid = 1'b1; a_readdata = 32'h999;
        @(negedge clk);
        chk("late_rdv", {h_readdatavalid, h_readdata, busy}, {4'b0000, 32'h0, 1'b0});
        nxt;
        a_readdatavalid = 1'b0; h_write = 4'b1000;
        @(negedge clk);
        chk("post_rst_req", {h_waitrequest, a_write}, {4'b1000, 1'b0});
        nxt;
        @(negedge clk);
        chk("post_rst_issue", {a_write, grant_idx, a_address, a_writedata, h_waitrequest},
            {1'b1, 2'd3, 32'h300, 32'h33333333, 4'b0000});
        nxt;
        h_write = 4'b0000;
        @(negedge clk);
        chk("post_rst_idle", {busy, a_write}, {1'b0, 1'b0});

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
